// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared types and constants for the stream to SDRAM bridge
package bridge_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } fifo_entry_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wshb_fifo.sv
// rtl/wshb_fifo.sv - single-clock FIFO of buffered Wishbone write requests
module wshb_fifo
    import bridge_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fifo_entry_t            push_entry,
    input  logic                   pop,
    output fifo_entry_t            head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt level.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    // Storage needs no reset: level gates whether any slot is ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/stream_to_sdram_bridge.sv
// rtl/stream_to_sdram_bridge.sv - buffers stream-bus writes and replays them as single SDRAM writes
module stream_to_sdram_bridge
    import bridge_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] BASE_ADR = 32'h0
)
(
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   s_cyc,
    input  logic                   s_stb,
    input  logic                   s_we,
    input  logic [31:0]            s_adr,
    input  logic [31:0]            s_dat_ms,
    input  logic [3:0]             s_sel,
    output logic                   s_ack,
    output logic                   s_err,
    output logic                   s_rty,
    output logic [31:0]            s_dat_sm,
    output logic                   m_cyc,
    output logic                   m_stb,
    output logic                   m_we,
    output logic [31:0]            m_adr,
    output logic [31:0]            m_dat_ms,
    output logic [3:0]             m_sel,
    output logic [2:0]             m_cti,
    output logic [1:0]             m_bte,
    input  logic                   m_ack,
    input  logic                   m_err,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err_flag
);

    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        rd_req;
    logic        pop;
    logic        err_set;

    state_t      state;
    state_t      state_d;
    logic        m_cyc_d;
    logic        m_stb_d;
    logic        m_we_d;
    logic [31:0] m_adr_d;
    logic [31:0] m_dat_ms_d;
    logic [3:0]  m_sel_d;

    // Reads are never served with data and retries are never requested.
    assign s_dat_sm = 32'h0;
    assign s_rty    = 1'b0;
    assign m_cti    = CTI_CLASSIC;
    assign m_bte    = BTE_LINEAR;

    // Fullness comes from the registered level, so a same-cycle pop never frees a slot early.
    assign accept = s_cyc & s_stb & s_we & ~s_ack & ~fifo_full;
    assign rd_req = s_cyc & s_stb & ~s_we & ~s_err;

    assign push_entry.adr = s_adr;
    assign push_entry.dat = s_dat_ms;
    assign push_entry.sel = s_sel;

    wshb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .level      (level),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // One-cycle stream terminations: ack for accepted writes, err for any read.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
        end else begin
            s_ack <= accept;
            s_err <= rd_req;
        end
    end

    // Master FSM next state and registered SDRAM outputs; outputs hold unless changed.
    always_comb begin
        state_d    = state;
        m_cyc_d    = m_cyc;
        m_stb_d    = m_stb;
        m_we_d     = m_we;
        m_adr_d    = m_adr;
        m_dat_ms_d = m_dat_ms;
        m_sel_d    = m_sel;
        pop        = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = WRITE;
                    m_cyc_d    = 1'b1;
                    m_stb_d    = 1'b1;
                    m_we_d     = 1'b1;
                    m_adr_d    = head.adr + BASE_ADR;
                    m_dat_ms_d = head.dat;
                    m_sel_d    = head.sel;
                end
            end
            WRITE: begin
                // An error termination wins over a simultaneous ack; the word is dropped either way.
                if (m_ack || m_err) begin
                    state_d    = IDLE;
                    pop        = 1'b1;
                    err_set    = m_err;
                    m_cyc_d    = 1'b0;
                    m_stb_d    = 1'b0;
                    m_we_d     = 1'b0;
                    m_adr_d    = 32'h0;
                    m_dat_ms_d = 32'h0;
                    m_sel_d    = 4'h0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Master state and output registers; reset abandons any cycle in flight.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            m_cyc    <= 1'b0;
            m_stb    <= 1'b0;
            m_we     <= 1'b0;
            m_adr    <= 32'h0;
            m_dat_ms <= 32'h0;
            m_sel    <= 4'h0;
        end else begin
            state    <= state_d;
            m_cyc    <= m_cyc_d;
            m_stb    <= m_stb_d;
            m_we     <= m_we_d;
            m_adr    <= m_adr_d;
            m_dat_ms <= m_dat_ms_d;
            m_sel    <= m_sel_d;
        end
    end

    // Sticky SDRAM error indicator, cleared only by reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_flag <= 1'b0;
        end else if (err_set) begin
            err_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_to_sdram_bridge.sv
// tb/tb_stream_to_sdram_bridge.sv - directed scoreboard bench for stream_to_sdram_bridge
module tb_stream_to_sdram_bridge;
    import bridge_pkg::*;

    localparam int          DEPTH  = 4;
    localparam int          LW     = $clog2(DEPTH) + 1;
    localparam logic [31:0] BASE_A = 32'h0000_1000;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFF0;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [31:0]   s_adr = 32'h0, s_dat_ms = 32'h0;
    logic [3:0]    s_sel = 4'h0;
    logic          m_ack = 1'b0, m_err = 1'b0;

    logic          s_ack_a, s_err_a, s_rty_a, m_cyc_a, m_stb_a, m_we_a, err_flag_a;
    logic [31:0]   s_dat_sm_a, m_adr_a, m_dat_ms_a;
    logic [3:0]    m_sel_a;
    logic [2:0]    m_cti_a;
    logic [1:0]    m_bte_a;
    logic [LW-1:0] level_a;

    logic          s_ack_b, s_err_b, s_rty_b, m_cyc_b, m_stb_b, m_we_b, err_flag_b;
    logic [31:0]   s_dat_sm_b, m_adr_b, m_dat_ms_b;
    logic [3:0]    m_sel_b;
    logic [2:0]    m_cti_b;
    logic [1:0]    m_bte_b;
    logic [LW-1:0] level_b;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_xfer = 0;
    bit            hold_ack = 1'b0;
    bit            err_once = 1'b0;
    fifo_entry_t   sb[$];

    always #5 sys_clk = ~sys_clk;

    stream_to_sdram_bridge #(.DEPTH(DEPTH), .BASE_ADR(BASE_A)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel),
        .s_ack(s_ack_a), .s_err(s_err_a), .s_rty(s_rty_a), .s_dat_sm(s_dat_sm_a),
        .m_cyc(m_cyc_a), .m_stb(m_stb_a), .m_we(m_we_a), .m_adr(m_adr_a), .m_dat_ms(m_dat_ms_a),
        .m_sel(m_sel_a), .m_cti(m_cti_a), .m_bte(m_bte_a), .m_ack(m_ack), .m_err(m_err),
        .level(level_a), .err_flag(err_flag_a)
    );

    stream_to_sdram_bridge #(.DEPTH(DEPTH), .BASE_ADR(BASE_B)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel),
        .s_ack(s_ack_b), .s_err(s_err_b), .s_rty(s_rty_b), .s_dat_sm(s_dat_sm_b),
        .m_cyc(m_cyc_b), .m_stb(m_stb_b), .m_we(m_we_b), .m_adr(m_adr_b), .m_dat_ms(m_dat_ms_b),
        .m_sel(m_sel_b), .m_cti(m_cti_b), .m_bte(m_bte_b), .m_ack(m_ack), .m_err(m_err),
        .level(level_b), .err_flag(err_flag_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        fifo_entry_t e;
        int n;
        e.adr = adr;
        e.dat = dat;
        e.sel = sel;
        sb.push_back(e);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
        s_adr = adr; s_dat_ms = dat; s_sel = sel;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_ack_a && n < 50);
        if (!s_ack_a) check("sw_ack_timeout", 32'(s_ack_a), 32'd1);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || level_a != '0 || m_cyc_a) && n < limit) begin
            tick();
            n++;
        end
        check("drain_sb", 32'(sb.size()), 32'd0);
        check("drain_level", 32'(level_a), 32'd0);
    endtask

    // SDRAM slave model: terminates each presented write and scores it against the stream order.
    always @(posedge sys_clk) begin
        fifo_entry_t e;
        #1;
        if (m_ack || m_err) begin
            m_ack = 1'b0;
            m_err = 1'b0;
        end else if (m_cyc_a && m_stb_a && !hold_ack && !sys_rst) begin
            n_xfer++;
            if (sb.size() == 0) begin
                check("sb_underflow_adr", m_adr_a, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                check("sd_adr_a", m_adr_a, e.adr + BASE_A);
                check("sd_adr_b", m_adr_b, e.adr + BASE_B);
                check("sd_dat", m_dat_ms_a, e.dat);
                check("sd_sel_we_cti_bte", {22'h0, m_sel_a, m_we_a, m_cti_a, m_bte_a},
                      {22'h0, e.sel, 1'b1, 3'b000, 2'b00});
            end
            if (err_once) begin
                m_err = 1'b1;
                err_once = 1'b0;
            end else begin
                m_ack = 1'b1;
            end
        end
    end

    initial begin
        int x0;
        int n;
        bit saw3;
        fifo_entry_t e;

        repeat (3) tick();
        sys_rst = 1'b0;
        tick();

        // Reset then idle: every output low.
        check("rst_m_ctl", {29'h0, m_cyc_a, m_stb_a, m_we_a}, 32'h0);
        check("rst_m_adr", m_adr_a, 32'h0);
        check("rst_m_dat", m_dat_ms_a, 32'h0);
        check("rst_s_term", {24'h0, m_sel_a, s_ack_a, s_err_a, s_rty_a, err_flag_a}, 32'h0);
        check("rst_s_dat", s_dat_sm_a, 32'h0);
        check("rst_level", 32'(level_a), 32'h0);
        check("rst_b", {24'h0, m_cyc_b, s_ack_b, s_err_b, s_rty_b, err_flag_b, level_b}, 32'h0);

        // Single write with zero SDRAM wait states and exact cycle timing.
        e.adr = 32'h10; e.dat = 32'hCAFE_F00D; e.sel = 4'hF;
        sb.push_back(e);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
        s_adr = 32'h10; s_dat_ms = 32'hCAFE_F00D; s_sel = 4'hF;
        tick();
        check("t1_s_ack_n1", 32'(s_ack_a), 32'd1);
        check("t1_level_n1", 32'(level_a), 32'd1);
        check("t1_m_cyc_n1", 32'(m_cyc_a), 32'd0);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        tick();
        check("t1_s_ack_n2", 32'(s_ack_a), 32'd0);
        check("t1_m_stb_n2", {30'h0, m_cyc_a, m_stb_a}, 32'd3);
        check("t1_m_adr", m_adr_a, 32'h1010);
        check("t1_m_dat", m_dat_ms_a, 32'hCAFE_F00D);
        check("t1_m_sel", 32'(m_sel_a), 32'hF);
        tick();
        check("t1_m_cyc_n3", 32'(m_cyc_a), 32'd0);
        check("t1_level_n3", 32'(level_a), 32'd0);

        // Stream read: one-cycle err, nothing buffered, no SDRAM cycle.
        x0 = n_xfer;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h40;
        tick();
        check("rd_s_err", 32'(s_err_a), 32'd1);
        check("rd_s_ack", 32'(s_ack_a), 32'd0);
        check("rd_s_dat_rty", {s_dat_sm_a[30:0], s_rty_a}, 32'h0);
        s_cyc = 1'b0; s_stb = 1'b0;
        tick();
        check("rd_s_err_once", 32'(s_err_a), 32'd0);
        check("rd_level", 32'(level_a), 32'd0);
        repeat (5) tick();
        check("rd_no_sdram", 32'(n_xfer - x0), 32'd0);
        check("rd_m_cyc", 32'(m_cyc_a), 32'd0);

        // Fill to DEPTH with SDRAM stalled, then release and watch the fifth word get in.
        x0 = n_xfer;
        hold_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            sw(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1));
        end
        check("full_level", 32'(level_a), 32'd4);
        e.adr = 32'h200; e.dat = 32'hB5B5_0005; e.sel = 4'h5;
        sb.push_back(e);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
        s_adr = e.adr; s_dat_ms = e.dat; s_sel = e.sel;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_no_ack", 32'(s_ack_a), 32'd0);
            check("full_level_hold", 32'(level_a), 32'd4);
        end
        hold_ack = 1'b0;
        saw3 = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (level_a == LW'(3) && !s_ack_a) saw3 = 1'b1;
        end while (!s_ack_a && n < 50);
        check("full_5th_ack", 32'(s_ack_a), 32'd1);
        check("full_ack_after_l3", 32'(saw3), 32'd1);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        wait_idle(200);
        check("full_xfers", 32'(n_xfer - x0), 32'd5);

        // SDRAM error on the first of two words.
        x0 = n_xfer;
        err_once = 1'b1;
        sw(32'h300, 32'h1111_2222, 4'hF);
        sw(32'h304, 32'h3333_4444, 4'hC);
        wait_idle(200);
        check("err_flag", {31'h0, err_flag_a}, 32'd1);
        check("err_flag_b", {31'h0, err_flag_b}, 32'd1);
        check("err_xfers", 32'(n_xfer - x0), 32'd2);

        // Address wrap on the high-offset instance.
        sw(32'h20, 32'h1234_5678, 4'h3);
        tick();
        check("wrap_m_stb_b", 32'(m_stb_b), 32'd1);
        check("wrap_m_adr_b", m_adr_b, 32'h0000_0010);
        check("wrap_m_adr_a", m_adr_a, 32'h0000_1020);
        wait_idle(200);
        check("err_flag_sticky", {31'h0, err_flag_a}, 32'd1);

        // Asynchronous reset in the middle of a stalled write.
        hold_ack = 1'b1;
        sw(32'h400, 32'h0000_0001, 4'hF);
        sw(32'h404, 32'h0000_0002, 4'hF);
        sw(32'h408, 32'h0000_0003, 4'hF);
        repeat (2) tick();
        check("arst_pre_cyc", 32'(m_cyc_a), 32'd1);
        check("arst_pre_level", 32'(level_a), 32'd3);
        sys_rst = 1'b1;
        #1;
        check("arst_m_cyc", {30'h0, m_cyc_a, m_stb_a}, 32'd0);
        check("arst_level", 32'(level_a), 32'd0);
        check("arst_m_cyc_b", 32'(m_cyc_b), 32'd0);
        sb.delete();
        x0 = n_xfer;
        tick();
        sys_rst = 1'b0;
        hold_ack = 1'b0;
        repeat (10) tick();
        check("arst_no_sdram", 32'(n_xfer - x0), 32'd0);
        check("arst_idle", {30'h0, m_cyc_a, err_flag_a}, 32'd0);
        check("arst_level_post", 32'(level_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
